// File: rtl/line_raster.sv
// Bresenham line rasteriser: latches two endpoints and a colour, then streams one pixel per clock.
// Latency: first pixel two edges after the accepting edge; no backpressure, start is ignored while busy.
module line_raster #(
    parameter int WIDTH_BITS = 6,
    parameter int COLOR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH_BITS-1:0] x0,
    input  logic [WIDTH_BITS-1:0] y0,
    input  logic [WIDTH_BITS-1:0] x1,
    input  logic [WIDTH_BITS-1:0] y1,
    input  logic [COLOR_BITS-1:0] color_in,
    output logic                  busy,
    output logic                  valid,
    output logic [WIDTH_BITS-1:0] x,
    output logic [WIDTH_BITS-1:0] y,
    output logic [COLOR_BITS-1:0] color_out
);

    localparam int AW = WIDTH_BITS + 3;
    localparam logic [WIDTH_BITS-1:0] ONE = WIDTH_BITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [WIDTH_BITS-1:0]   r_x0, r_y0, r_x1, r_y1;
    logic [WIDTH_BITS-1:0]   r_cx, r_cy;
    logic [COLOR_BITS-1:0]   r_color;
    logic signed [AW-1:0]    r_dx, r_dy, r_err;
    logic                    r_sx, r_sy;
    logic                    r_last;

    logic [WIDTH_BITS-1:0]   w_adx, w_ady;
    logic signed [AW-1:0]    w_dx_ext, w_dy_ext;
    logic signed [AW-1:0]    w_e2, w_add_x, w_add_y, w_err_nxt;
    logic                    w_step_x, w_step_y, w_at_end, w_accept;
    logic [WIDTH_BITS-1:0]   w_cx_nxt, w_cy_nxt;

    assign w_adx    = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    assign w_ady    = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
    assign w_dx_ext = $signed({3'b000, w_adx});
    assign w_dy_ext = $signed({3'b000, w_ady});

    // err is bounded by [dy, dx], so doubling it cannot leave AW bits
    assign w_e2      = r_err <<< 1;
    assign w_step_x  = (w_e2 >= r_dy);
    assign w_step_y  = (w_e2 <= r_dx);
    assign w_add_x   = w_step_x ? r_dy : $signed(AW'(0));
    assign w_add_y   = w_step_y ? r_dx : $signed(AW'(0));
    assign w_err_nxt = r_err + w_add_x + w_add_y;
    assign w_cx_nxt  = w_step_x ? (r_sx ? r_cx + ONE : r_cx - ONE) : r_cx;
    assign w_cy_nxt  = w_step_y ? (r_sy ? r_cy + ONE : r_cy - ONE) : r_cy;
    assign w_at_end  = (r_cx == r_x1) && (r_cy == r_y1);

    // A start arriving on the edge the finished line retires is taken as a back-to-back request
    assign w_accept  = start && ((r_state == IDLE) || ((r_state == DRAW) && r_last));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_x0      <= '0;
            r_y0      <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_color   <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_err     <= '0;
            r_sx      <= 1'b0;
            r_sy      <= 1'b0;
            r_last    <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            x         <= '0;
            y         <= '0;
            color_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
                SETUP: begin
                    r_dx    <= w_dx_ext;
                    r_dy    <= -w_dy_ext;
                    r_sx    <= (r_x0 < r_x1);
                    r_sy    <= (r_y0 < r_y1);
                    r_err   <= w_dx_ext - w_dy_ext;
                    r_cx    <= r_x0;
                    r_cy    <= r_y0;
                    r_state <= DRAW;
                end
                DRAW: begin
                    if (r_last) begin
                        busy    <= 1'b0;
                        valid   <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        valid     <= 1'b1;
                        x         <= r_cx;
                        y         <= r_cy;
                        color_out <= r_color;
                        if (w_at_end) begin
                            r_last <= 1'b1;
                        end else begin
                            r_err <= w_err_nxt;
                            r_cx  <= w_cx_nxt;
                            r_cy  <= w_cy_nxt;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    valid   <= 1'b0;
                end
            endcase

            if (w_accept) begin
                r_x0    <= x0;
                r_y0    <= y0;
                r_x1    <= x1;
                r_y1    <= y1;
                r_color <= color_in;
                r_last  <= 1'b0;
                busy    <= 1'b1;
                valid   <= 1'b0;
                r_state <= SETUP;
            end
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// Randomised and directed bench for line_raster against an integer Bresenham model.
module tb_line_raster;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] x0, y0, x1, y1;
    logic [7:0] color_in;
    logic       busy, valid;
    logic [5:0] x, y;
    logic [7:0] color_out;

    int n_chk = 0;
    int n_err = 0;
    logic [11:0] px_q[$];

    line_raster #(.WIDTH_BITS(6), .COLOR_BITS(8)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .color_in (color_in),
        .busy     (busy),
        .valid    (valid),
        .x        (x),
        .y        (y),
        .color_out(color_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {10'b0, valid, busy, x, y, color_out};
    endfunction

    function automatic logic [31:0] vb();
        return {30'b0, valid, busy};
    endfunction

    task automatic scramble();
        x0       = 6'($urandom);
        y0       = 6'($urandom);
        x1       = 6'($urandom);
        y1       = 6'($urandom);
        color_in = 8'($urandom);
    endtask

    // Reference pixel list from the integer Bresenham rule
    task automatic model_line(input int ax, input int ay, input int bx, input int by);
        int dx, dy, sx, sy, err, e2, cx, cy;
        px_q.delete();
        dx  = (bx > ax) ? bx - ax : ax - bx;
        dy  = -((by > ay) ? by - ay : ay - by);
        sx  = (ax < bx) ? 1 : -1;
        sy  = (ay < by) ? 1 : -1;
        err = dx + dy;
        cx  = ax;
        cy  = ay;
        forever begin
            px_q.push_back({6'(cx), 6'(cy)});
            if (cx == bx && cy == by) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; cx += sx; end
            if (e2 <= dx) begin err += dx; cy += sy; end
        end
    endtask

    task automatic drive(input int ax, input int ay, input int bx, input int by, input logic [7:0] col);
        x0       = 6'(ax);
        y0       = 6'(ay);
        x1       = 6'(bx);
        y1       = 6'(by);
        color_in = col;
        start    = 1'b1;
    endtask

    // Called just after a negedge; returns at the negedge following the accepting edge
    task automatic start_line(input int ax, input int ay, input int bx, input int by, input logic [7:0] col);
        drive(ax, ay, bx, by, col);
        @(negedge clk);
        start = 1'b0;
        scramble();
    endtask

    task automatic check_line(input string tag, input logic [7:0] col, input int inj_at,
                              input int ix0, input int iy0, input int ix1, input int iy1,
                              input logic [7:0] icol, input int abort_at);
        int n;
        logic [11:0] p;
        n = px_q.size();
        chk({tag, " setup0"}, vb(), 32'h1);
        @(negedge clk);
        chk({tag, " setup1"}, vb(), 32'h1);
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            p = px_q[k];
            chk($sformatf("%s px%0d", tag, k), obs(), {10'b0, 2'b11, p[11:6], p[5:0], col});
            if (k == abort_at) begin
                #1 rst_n = 1'b0;
                #1 chk({tag, " async_rst"}, obs(), 32'h0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    chk($sformatf("%s post_rst%0d", tag, j), vb(), 32'h0);
                end
                return;
            end
            if (k == inj_at) drive(ix0, iy0, ix1, iy1, icol);
            @(negedge clk);
            start = 1'b0;
            scramble();
        end
        if (inj_at != n - 1) chk({tag, " end"}, vb(), 32'h0);
    endtask

    initial begin
        int ax, ay, bx, by;
        logic [7:0] col;
        rst_n = 1'b0;
        start = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        chk("reset", obs(), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle", obs(), 32'h0);

        // Shallow diagonal with hand-derived pixels
        px_q = '{{6'd0, 6'd0}, {6'd1, 6'd1}, {6'd2, 6'd1}, {6'd3, 6'd2}, {6'd4, 6'd2}, {6'd5, 6'd3}};
        start_line(0, 0, 5, 3, 8'hA5);
        check_line("short", 8'hA5, -1, 0, 0, 0, 0, 8'h0, -1);

        px_q.delete();
        for (int i = 63; i >= 0; i--) px_q.push_back({6'(i), 6'd10});
        start_line(63, 10, 0, 10, 8'h3C);
        check_line("horiz", 8'h3C, -1, 0, 0, 0, 0, 8'h0, -1);

        px_q.delete();
        for (int i = 63; i >= 0; i--) px_q.push_back({6'd7, 6'(i)});
        start_line(7, 63, 7, 0, 8'hC3);
        check_line("vert", 8'hC3, -1, 0, 0, 0, 0, 8'h0, -1);

        // Single point: busy for setup0, setup1 and the pixel cycle only
        px_q = '{{6'd20, 6'd20}};
        start_line(20, 20, 20, 20, 8'h11);
        check_line("point", 8'h11, -1, 0, 0, 0, 0, 8'h0, -1);

        px_q.delete();
        for (int i = 0; i < 64; i++) px_q.push_back({6'(i), 6'(i)});
        start_line(0, 0, 63, 63, 8'h5A);
        check_line("diag_ign", 8'h5A, 10, 1, 2, 3, 4, 8'hFF, -1);
        repeat (3) begin
            @(negedge clk);
            chk("diag_ign idle", vb(), 32'h0);
        end

        px_q.delete();
        for (int i = 0; i <= 40; i++) px_q.push_back({6'(i), 6'd0});
        start_line(0, 0, 40, 0, 8'h77);
        check_line("abort", 8'h77, -1, 0, 0, 0, 0, 8'h0, 5);
        px_q = '{{6'd2, 6'd2}, {6'd3, 6'd2}, {6'd4, 6'd2}};
        start_line(2, 2, 4, 2, 8'h42);
        check_line("after_rst", 8'h42, -1, 0, 0, 0, 0, 8'h0, -1);

        // Second request raised during the last pixel cycle of the first line
        model_line(10, 5, 14, 7);
        start_line(10, 5, 14, 7, 8'h12);
        check_line("b2b_a", 8'h12, px_q.size() - 1, 30, 30, 25, 40, 8'h34, -1);
        model_line(30, 30, 25, 40);
        check_line("b2b_b", 8'h34, -1, 0, 0, 0, 0, 8'h0, -1);

        for (int t = 0; t < 16; t++) begin
            ax  = $urandom_range(0, 63);
            ay  = $urandom_range(0, 63);
            bx  = $urandom_range(0, 63);
            by  = $urandom_range(0, 63);
            col = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            model_line(ax, ay, bx, by);
            start_line(ax, ay, bx, by, col);
            check_line($sformatf("rnd%0d", t), col, -1, 0, 0, 0, 0, 8'h0, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/line_raster.md
Name: line_raster

Overview:
- Bresenham line rasteriser. Takes two endpoints and a colour, then emits one pixel coordinate per clock until the line is complete.
- Sits between the line bench controller (upstream: `start`, endpoints, colour) and the sprite bitmap write path (downstream: `valid`, `x`, `y`, `color_out`).
- Drop-in alternative rasteriser for the line benchmark. Port-compatible with the existing line engine apart from reset polarity.

Parameters:
- WIDTH_BITS, 6, coordinate width in bits; the plane is 2^WIDTH_BITS x 2^WIDTH_BITS.
- COLOR_BITS, 8, colour width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  single-cycle request to begin a line.
- x0  input  WIDTH_BITS  start point X.
- y0  input  WIDTH_BITS  start point Y.
- x1  input  WIDTH_BITS  end point X.
- y1  input  WIDTH_BITS  end point Y.
- color_in  input  COLOR_BITS  line colour.
- busy  output  1  high from the edge after `start` is accepted until the edge after the last pixel.
- valid  output  1  current `x`/`y`/`color_out` form a pixel to write.
- x  output  WIDTH_BITS  pixel X.
- y  output  WIDTH_BITS  pixel Y.
- color_out  output  COLOR_BITS  pixel colour; equals the latched `color_in`.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, valid, x, y, color_out and all internal registers = 0.
  - Asserting reset mid-line aborts the line immediately; no further valid pulses after release.
- States: IDLE, SETUP, DRAW.
- IDLE:
  - busy=0, valid=0.
  - On an edge with start=1: latch x0, y0, x1, y1, color_in; go to SETUP; busy=1 from that edge.
  - Inputs need not be held after the accepting edge.
- SETUP (one cycle). Registers computed:
  - dx = |x1-x0|
  - dy = -|y1-y0|
  - sx = +1 if x0<x1, else -1
  - sy = +1 if y0<y1, else -1
  - err = dx+dy
  - cur = (x0, y0)
  - Then go to DRAW.
- DRAW, each edge:
  - Drive valid=1, x/y=cur, color_out=colour.
  - If cur==(x1,y1): go to DONE_FLAG, meaning the next edge returns to IDLE with busy=0 and valid=0.
  - Otherwise, with e2=2*err:
    - if e2>=dy: err+=dy, cur.x+=sx.
    - if e2<=dx: err+=dx, cur.y+=sy.
    - Both conditions may apply in the same cycle; the err updates sum.
- DONE_FLAG is implemented as DRAW sampling the "last" condition. States remain exactly IDLE/SETUP/DRAW.
- Latency: `start` accepted at edge E0 → busy=1 after E0 → first valid=1 after E2. Pixel count N = max(dx,|dy|)+1, one per cycle with no gaps. The last valid is high during the cycle after edge E2+N-1; busy and valid both fall at edge E2+N.
- busy stays high in every cycle where valid is high.
- Arithmetic:
  - dx, dy, err, e2 are signed, WIDTH_BITS+3 bits; no overflow for any endpoint pair.
  - cur stays within [0, 2^WIDTH_BITS-1]; no wrap-around is ever produced.
- start while busy=1 is ignored: no latch, no effect on the current line.
- start on the same edge busy falls (back-to-back) is accepted.
- Degenerate line (x0==x1 and y0==y1): exactly one valid pixel; busy high for 3 cycles.
- Horizontal and vertical lines, and both directions on each axis, are handled by sx/sy.
- Endpoints are always emitted: first pixel = (x0,y0), last = (x1,y1).

Test Plan:
- Reset release; start with (0,0)→(5,3), colour 0xA5 → exactly 6 valid pixels in consecutive cycles: (0,0),(1,1),(2,1),(3,2),(4,2),(5,3), all with color_out=0xA5. First valid 2 cycles after the start edge; busy falls with valid.
- (63,10)→(0,10) → 64 pixels with x=63..0 descending and y=10 constant. Then (7,63)→(7,0) → 64 pixels with y descending and x=7.
- (20,20)→(20,20) → exactly 1 valid pixel (20,20); busy high for exactly 3 cycles.
- Line (0,0)→(63,63) in progress; pulse start with (1,2)→(3,4) at pixel 10 → ignored. All 64 diagonal pixels emitted; no pixel from the second line appears.
- Assert reset at pixel 5 of (0,0)→(40,0) → busy, valid, x, y go to 0 asynchronously, before the next edge. After release, no valid until a new start; the new line (2,2)→(4,2) emits exactly 3 pixels.
- Back-to-back: start asserted on the edge busy falls → accepted; the second line's first valid appears 2 cycles later.
